pipe_scheduler: RTL and testbench

Game-object sequencer that owns the three pipe slots drawn by the display block and produces its pipe_1/pipe_2/pipe_3 words.
- On each frame tick it scrolls every slot left, one slot per clock, through a single shared adder.
- Slots that leave the screen on the left are respawned with an LFSR-chosen height.
- A one-cycle score pulse is issued each time a pipe's trailing edge passes the character column.
- It sits between the game FSM (start/run) and the display, clocked on the system clk.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/pipe_lfsr.sv | 32 +++
 rtl/pipe_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_pipe_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared constants, pipe-word layout and FSM encoding for the pipe
//            scheduler and its LFSR.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int c_word_vis_bit = 31;
    localparam int c_word_gap_lsb = 20;
    localparam int c_word_x_lsb   = 10;
    localparam int c_word_h_lsb   = 0;

    localparam int          c_park_x    = 700;
    localparam logic [15:0] c_lfsr_taps = 16'hB400;  // bits 15, 13, 12, 10
    localparam logic [15:0] c_lfsr_seed = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT0 = 3'd1,
        S_INIT1 = 3'd2,
        S_INIT2 = 3'd3,
        S_WAIT  = 3'd4,
        S_UPD0  = 3'd5,
        S_UPD1  = 3'd6,
        S_UPD2  = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : pipe_lfsr
// Purpose  : 16-bit Fibonacci LFSR (shift left) that steps only when asked;
//            the next value is offered combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_lfsr
    import pipe_pkg::*;
#(
    parameter logic [15:0] SEED = c_lfsr_seed
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        advance,
    output logic [15:0] lfsr_next
);

    logic [15:0] r_lfsr;

    assign lfsr_next = {r_lfsr[14:0], ^(r_lfsr & c_lfsr_taps)};

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_lfsr <= SEED;
        end else if (advance) begin
            r_lfsr <= lfsr_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pipe_scheduler
// Purpose  : Owns three pipe slots; scrolls them one slot per clock on each
//            frame tick, respawns off-screen slots and counts passed pipes.
//            Optional: PIPE_GAP_SHRINK_EN narrows the gap every 8 points.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_scheduler
    import pipe_pkg::*;
#(
    parameter int          SCREEN_W  = 640,
    parameter int          PIPE_W    = 50,
    parameter int          SPACING   = 240,
    parameter int          SPEED     = 2,
    parameter int          MARIO_X   = 40,
    parameter int          MIN_H     = 60,
    parameter int          GAP       = 120,
    parameter int          PARK_X    = c_park_x,
    parameter logic [15:0] LFSR_SEED = c_lfsr_seed
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        start,
    input  logic        run,
    input  logic        frame_tick,
    output logic [31:0] pipe_1,
    output logic [31:0] pipe_2,
    output logic [31:0] pipe_3,
    output logic        score_inc,
    output logic [15:0] score,
    output logic        busy
);

    localparam logic signed [11:0] c_speed      = 12'(SPEED);
    localparam logic signed [11:0] c_vis_lo     = 12'(-(PIPE_W - 1));
    localparam logic signed [11:0] c_vis_hi     = 12'(SCREEN_W - 1);
    localparam logic signed [11:0] c_retire_lim = 12'(-PIPE_W);
    localparam logic signed [11:0] c_score_lim  = 12'(MARIO_X - PIPE_W);
    localparam logic signed [11:0] c_wrap       = 12'(3 * SPACING);
    localparam logic signed [11:0] c_init_x0    = 12'(SCREEN_W);
    localparam logic signed [11:0] c_init_x1    = 12'(SCREEN_W + SPACING);
    localparam logic signed [11:0] c_init_x2    = 12'(SCREEN_W + 2 * SPACING);
    localparam logic signed [11:0] c_x_park     = 12'(PARK_X);
    localparam logic [9:0]         c_park       = 10'(PARK_X);
    localparam logic [9:0]         c_min_h      = 10'(MIN_H);
    localparam logic [7:0]         c_gap        = 8'(GAP);

    function automatic logic [31:0] pack_word(input logic signed [11:0] x,
                                              input logic [7:0] g,
                                              input logic [9:0] h);
        logic vis;
        pack_word = '0;
        vis = (x >= c_vis_lo) && (x <= c_vis_hi);
        pack_word[c_word_vis_bit]      = vis;
        pack_word[c_word_gap_lsb +: 8] = g;
        pack_word[c_word_x_lsb +: 10]  = vis ? x[9:0] : c_park;
        pack_word[c_word_h_lsb +: 10]  = h;
    endfunction

    state_t             r_state, w_state_next;
    logic               w_is_init, w_is_upd, w_act, w_load;
    logic [1:0]         w_slot;
    logic signed [11:0] r_x [3];
    logic [9:0]         r_h [3];
    logic [7:0]         r_g [3];
    logic [31:0]        r_word [3];
    logic signed [11:0] w_x_cur, w_x_new, w_x_wr;
    logic [9:0]         w_h_wr, w_h_load;
    logic [7:0]         w_g_wr, w_gap_use;
    logic               w_score_evt, w_retire;
    logic [15:0]        r_score;
    logic               r_score_inc;
    logic [15:0]        w_lfsr_next;
    logic               w_unused_lfsr;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_is_init    = 1'b0;
        w_is_upd     = 1'b0;
        w_slot       = 2'd0;
        case (r_state)
            S_INIT0: begin w_is_init = 1'b1; w_slot = 2'd0; end
            S_INIT1: begin w_is_init = 1'b1; w_slot = 2'd1; end
            S_INIT2: begin w_is_init = 1'b1; w_slot = 2'd2; end
            S_UPD0:  begin w_is_upd  = 1'b1; w_slot = 2'd0; end
            S_UPD1:  begin w_is_upd  = 1'b1; w_slot = 2'd1; end
            S_UPD2:  begin w_is_upd  = 1'b1; w_slot = 2'd2; end
            default: ;
        endcase
        if (start) begin
            w_state_next = S_INIT0;
        end else begin
            case (r_state)
                S_IDLE:  w_state_next = S_IDLE;
                S_INIT0: w_state_next = S_INIT1;
                S_INIT1: w_state_next = S_INIT2;
                S_INIT2: w_state_next = S_WAIT;
                S_WAIT:  if (frame_tick && run) w_state_next = S_UPD0;
                S_UPD0:  w_state_next = S_UPD1;
                S_UPD1:  w_state_next = S_UPD2;
                S_UPD2:  w_state_next = S_WAIT;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign busy = w_is_init | w_is_upd;

    // A start request pre-empts whatever slot action the current state would do.
    assign w_act       = ~start;
    assign w_x_cur     = r_x[w_slot];
    assign w_x_new     = w_x_cur - c_speed;
    assign w_score_evt = w_is_upd && (w_x_cur > c_score_lim) && (w_x_new <= c_score_lim);
    assign w_retire    = w_is_upd && (w_x_new <= c_retire_lim);
    assign w_load      = w_act && (w_is_init || w_retire);
    assign w_h_load    = c_min_h + {2'b00, w_lfsr_next[7:0]};
    assign w_unused_lfsr = ^w_lfsr_next[15:8];

    pipe_lfsr #(
        .SEED      (LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .clrn      (clrn),
        .advance   (w_load),
        .lfsr_next (w_lfsr_next)
    );

    always_comb begin
        w_x_wr = w_x_new;
        if (w_is_init) begin
            case (w_slot)
                2'd1:    w_x_wr = c_init_x1;
                2'd2:    w_x_wr = c_init_x2;
                default: w_x_wr = c_init_x0;
            endcase
        end else if (w_retire) begin
            w_x_wr = w_x_new + c_wrap;
        end
        w_h_wr = w_load ? w_h_load  : r_h[w_slot];
        w_g_wr = w_load ? w_gap_use : r_g[w_slot];
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < 3; i++) begin
                r_x[i]    <= c_x_park;
                r_h[i]    <= '0;
                r_g[i]    <= '0;
                r_word[i] <= pack_word(c_x_park, 8'd0, 10'd0);
            end
        end else if (w_act && (w_is_init || w_is_upd)) begin
            r_x[w_slot]    <= w_x_wr;
            r_h[w_slot]    <= w_h_wr;
            r_g[w_slot]    <= w_g_wr;
            r_word[w_slot] <= pack_word(w_x_wr, w_g_wr, w_h_wr);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_score     <= '0;
            r_score_inc <= 1'b0;
        end else begin
            r_score_inc <= w_act && w_score_evt;
            if (w_act && (r_state == S_INIT0)) begin
                r_score <= '0;
            end else if (w_act && w_score_evt && (r_score != 16'hFFFF)) begin
                r_score <= r_score + 16'd1;
            end
        end
    end

`ifdef PIPE_GAP_SHRINK_EN
    localparam logic [7:0] c_gap_floor = 8'd64;
    logic [7:0] r_gap;

    // Shrinks when the score is about to wrap its low three bits to zero.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_gap <= c_gap;
        end else if (w_act && (r_state == S_INIT0)) begin
            r_gap <= c_gap;
        end else if (w_act && w_score_evt && (r_score != 16'hFFFF) && (r_score[2:0] == 3'd7)) begin
            r_gap <= (r_gap >= c_gap_floor + 8'd4) ? r_gap - 8'd4 : c_gap_floor;
        end
    end

    assign w_gap_use = (r_state == S_INIT0) ? c_gap : r_gap;
`else
    assign w_gap_use = c_gap;
`endif

    assign pipe_1    = r_word[0];
    assign pipe_2    = r_word[1];
    assign pipe_3    = r_word[2];
    assign score     = r_score;
    assign score_inc = r_score_inc;

endmodule
`default_nettype wire

// File: tb/tb_pipe_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pipe_scheduler
// Purpose  : Self-checking bench for pipe_scheduler: directed table, corner
//            sequences and a randomized run against a slot-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_scheduler;

    localparam int SCREEN_W  = 640;
    localparam int PIPE_W    = 50;
    localparam int SPACING   = 240;
    localparam int SPEED     = 2;
    localparam int MARIO_X   = 40;
    localparam int MIN_H     = 60;
    localparam int GAP       = 120;
    localparam int PARK_X    = 700;
    localparam int LFSR_SEED = 'hACE1;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        start = 1'b0;
    logic        run = 1'b0;
    logic        frame_tick = 1'b0;
    logic [31:0] pipe_1, pipe_2, pipe_3;
    logic        score_inc;
    logic [15:0] score;
    logic        busy;

    always #5 clk = ~clk;

    pipe_scheduler dut (
        .clk        (clk),
        .clrn       (clrn),
        .start      (start),
        .run        (run),
        .frame_tick (frame_tick),
        .pipe_1     (pipe_1),
        .pipe_2     (pipe_2),
        .pipe_3     (pipe_3),
        .score_inc  (score_inc),
        .score      (score),
        .busy       (busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int pulse_cnt = 0;

    always @(negedge clk) if (score_inc === 1'b1) pulse_cnt++;

    // Slot-level reference: positions as plain integers, one sweep per tick.
    int mx [3];
    int mh [3];
    int mg [3];
    int mlfsr = LFSR_SEED;
    int mscore = 0;
    int mexp_inc = 0;
    int mgap = GAP;

    function automatic int lfsr_step(input int l);
        int fb;
        fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
        return ((l << 1) | fb) & 'hFFFF;
    endfunction

    function automatic void model_load(input int s, input int x);
        mlfsr = lfsr_step(mlfsr);
        mx[s] = x;
        mh[s] = MIN_H + (mlfsr & 255);
        mg[s] = mgap;
    endfunction

    function automatic void model_start();
        mscore = 0;
        mgap = GAP;
        for (int s = 0; s < 3; s++) model_load(s, SCREEN_W + s * SPACING);
    endfunction

    function automatic void model_tick();
        for (int s = 0; s < 3; s++) begin
            int nw;
            nw = mx[s] - SPEED;
            if ((mx[s] + PIPE_W > MARIO_X) && (nw + PIPE_W <= MARIO_X)) begin
                mexp_inc++;
                if (mscore < 65535) begin
                    mscore++;
`ifdef PIPE_GAP_SHRINK_EN
                    if (mscore % 8 == 0) mgap = (mgap - 4 < 64) ? 64 : mgap - 4;
`endif
                end
            end
            if (nw <= -PIPE_W) model_load(s, nw + 3 * SPACING);
            else mx[s] = nw;
        end
    endfunction

    function automatic logic [31:0] exp_word(input int s);
        bit vis;
        int xf;
        vis = (mx[s] >= -(PIPE_W - 1)) && (mx[s] <= SCREEN_W - 1);
        xf = vis ? (mx[s] & 1023) : PARK_X;
        return {vis, 3'b000, 8'(mg[s]), 10'(xf), 10'(mh[s])};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_pipe1"}, pipe_1, exp_word(0));
        chk({tag, "_pipe2"}, pipe_2, exp_word(1));
        chk({tag, "_pipe3"}, pipe_3, exp_word(2));
        chk({tag, "_score"}, 32'(score), 32'(mscore));
        chk({tag, "_pulses"}, 32'(pulse_cnt), 32'(mexp_inc));
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("busy_init", 32'(busy), 32'd1);
        cyc(); cyc(); cyc();
        model_start();
    endtask

    // Ticks captured 1..3 cycles after an accepted tick land in UPDx and must be dropped.
    task automatic do_tick(input bit r, input int spur, input bit drop);
        run = r;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        if (r) chk("busy_upd", 32'(busy), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            if (i == spur) frame_tick = 1'b1;
            if (drop && i == 1) run = 1'b0;
            cyc();
            frame_tick = 1'b0;
        end
        if (r) model_tick();
    endtask

    typedef struct {
        int ticks;
        int vis0;
        int x0;
        int vis1;
        int x1;
        int sc;
        int pulses;
    } row_t;

    row_t tbl [7];
    int   done_ticks;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0,   0, 700,  0, 700, 0, 0};
        tbl[1] = '{3,   1, 634,  0, 700, 0, 0};
        tbl[2] = '{320, 1, 0,    1, 240, 0, 0};
        tbl[3] = '{324, 1, 1016, 1, 232, 0, 0};
        tbl[4] = '{325, 1, 1014, 1, 230, 1, 1};
        tbl[5] = '{344, 1, 976,  1, 192, 1, 1};
        tbl[6] = '{345, 0, 700,  1, 190, 1, 1};

        // Reset state, then IDLE must ignore frame ticks.
        repeat (3) cyc();
        chk("rst_pipe1", pipe_1, 32'h000AF000);
        chk("rst_pipe2", pipe_2, 32'h000AF000);
        chk("rst_pipe3", pipe_3, 32'h000AF000);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_inc", 32'(score_inc), 32'd0);
        clrn = 1'b1;
        run = 1'b1;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
        chk("idle_pipe1", pipe_1, 32'h000AF000);
        chk("idle_busy", 32'(busy), 32'd0);

        // Directed table from a fresh start.
        do_start();
        done_ticks = 0;
        for (int i = 0; i < 7; i++) begin
            while (done_ticks < tbl[i].ticks) begin
                do_tick(1'b1, 0, 1'b0);
                done_ticks++;
            end
            chk("tbl_vis0", 32'(pipe_1[31]), 32'(tbl[i].vis0));
            chk("tbl_x0", 32'(pipe_1[19:10]), 32'(tbl[i].x0));
            chk("tbl_vis1", 32'(pipe_2[31]), 32'(tbl[i].vis1));
            chk("tbl_x1", 32'(pipe_2[19:10]), 32'(tbl[i].x1));
            chk("tbl_score", 32'(score), 32'(tbl[i].sc));
            chk("tbl_pulses", 32'(pulse_cnt), 32'(tbl[i].pulses));
            check_all("tbl");
        end

        // Spurious ticks during the sweep are dropped.
        for (int k = 1; k <= 3; k++) begin
            do_tick(1'b1, k, 1'b0);
            check_all("spur");
        end

        // run low: ten ticks, nothing moves.
        for (int k = 0; k < 10; k++) do_tick(1'b0, k % 4, 1'b0);
        check_all("frozen");

        // run falling inside the sweep still completes it.
        do_tick(1'b1, 0, 1'b1);
        check_all("rundrop");

        // start while in UPD1.
        run = 1'b1;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("mid_busy", 32'(busy), 32'd1);
        cyc(); cyc(); cyc();
        model_start();
        chk("mid_score", 32'(score), 32'd0);
        check_all("midstart");

        // Randomized play against the model.
        for (int it = 0; it < 500; it++) begin
            int r;
            r = $urandom_range(0, 39);
            if (r == 0) do_start();
            else do_tick($urandom_range(0, 4) != 0, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) cyc();
            check_all("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
